noc_inject_queue: RTL and testbench

- Sits directly downstream of the broadcast packet generator at the source node (0,0) of the 3x3 mesh.
- Absorbs its back-to-back 16-bit packet stream, which has no backpressure.
- Screens packets for legal destinations, buffers them in a FIFO and presents them to the local injection port of the router with a valid/ready handshake.
- Reports occupancy, overflow drops and illegal packets.

---
 rtl/noc_inject_queue.sv | 105 ++++++++++
 tb/tb_noc_inject_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/noc_inject_queue.sv
// rtl/noc_inject_queue.sv - screening FIFO between broadcast packet generator and router local port
// Drops illegal-destination packets, buffers legal ones first-word fall-through, sticky error flags.
module noc_inject_queue #(
  parameter int DEPTH  = 8,
  parameter int SELF_X = 0,
  parameter int SELF_Y = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              i_sdata,
  input  logic                     i_svalid,
  output logic [15:0]              o_pdata,
  output logic                     o_pvalid,
  input  logic                     i_pready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow,
  output logic                     o_bad_dest,
  output logic [7:0]               o_drop_cnt,
  input  logic                     i_clear
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] SX = 2'(SELF_X);
  localparam logic [1:0] SY = 2'(SELF_Y);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          bad_dest_q, bad_dest_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic          legal, push, pop, ovf_evt, bad_evt;
  logic [1:0]    dest_x, dest_y;

  always_comb begin
    dest_x = i_sdata[15:14];
    dest_y = i_sdata[13:12];
    legal  = (dest_x != 2'd3) && (dest_y != 2'd3) &&
             !((dest_x == SX) && (dest_y == SY)) &&
             (i_sdata[11:9] == 3'd0);
  end

  assign o_full   = (count_q == CW'(DEPTH));
  assign o_empty  = (count_q == '0);
  assign o_count  = count_q;
  assign o_pvalid = !o_empty;
  assign o_pdata  = o_pvalid ? mem_q[rd_ptr_q] : 16'd0;

  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign pop     = o_pvalid && i_pready;
  assign push    = i_svalid && legal && (!o_full || pop);
  assign ovf_evt = i_svalid && legal && o_full && !pop;
  assign bad_evt = i_svalid && !legal;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    bad_dest_d = bad_dest_q;
    drop_cnt_d = drop_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    // Clear takes priority over an event in the same cycle
    if (i_clear) begin
      overflow_d = 1'b0;
      bad_dest_d = 1'b0;
      drop_cnt_d = 8'd0;
    end else begin
      if (ovf_evt) overflow_d = 1'b1;
      if (bad_evt) bad_dest_d = 1'b1;
      if (ovf_evt && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      bad_dest_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      bad_dest_q <= bad_dest_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= i_sdata;
  end

  assign o_overflow = overflow_q;
  assign o_bad_dest = bad_dest_q;
  assign o_drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_noc_inject_queue.sv
// tb/tb_noc_inject_queue.sv - scoreboard bench for noc_inject_queue with queue-based reference model
module tb_noc_inject_queue;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] i_sdata = 16'd0;
  logic        i_svalid = 1'b0;
  logic        i_pready = 1'b0;
  logic        i_clear = 1'b0;
  logic [15:0] o_pdata;
  logic        o_pvalid, o_full, o_empty, o_overflow, o_bad_dest;
  logic [3:0]  o_count;
  logic [7:0]  o_drop_cnt;

  noc_inject_queue #(.DEPTH(DEPTH), .SELF_X(0), .SELF_Y(0)) dut (
    .clk(clk), .rst(rst), .i_sdata(i_sdata), .i_svalid(i_svalid),
    .o_pdata(o_pdata), .o_pvalid(o_pvalid), .i_pready(i_pready),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty),
    .o_overflow(o_overflow), .o_bad_dest(o_bad_dest),
    .o_drop_cnt(o_drop_cnt), .i_clear(i_clear)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit mon_en = 0;

  // Reference model: expected packet stream, occupancy, sticky flags
  logic [15:0] exp_q[$];
  int          m_cnt = 0;
  bit          m_ovf = 0, m_bad = 0;
  int          m_drop = 0;

  function automatic bit is_legal(input logic [15:0] d);
    int dx, dy;
    dx = int'(d[15:14]);
    dy = int'(d[13:12]);
    return (dx != 3) && (dy != 3) && !(dx == 0 && dy == 0) && (d[11:9] == 3'd0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      exp_q.delete();
      m_cnt  = 0;
      m_ovf  = 0;
      m_bad  = 0;
      m_drop = 0;
    end else begin
      bit p_pop, lg, p_push, ovf;
      p_pop  = (m_cnt > 0) && i_pready;
      lg     = is_legal(i_sdata);
      p_push = i_svalid && lg && ((m_cnt < DEPTH) || p_pop);
      ovf    = i_svalid && lg && (m_cnt == DEPTH) && !p_pop;
      if (p_push) exp_q.push_back(i_sdata);
      m_cnt = m_cnt + (p_push ? 1 : 0) - (p_pop ? 1 : 0);
      if (i_clear) begin
        m_ovf = 0; m_bad = 0; m_drop = 0;
      end else begin
        if (ovf) begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
        if (i_svalid && !lg) m_bad = 1;
      end
    end
  end

  // Monitor: compares state every cycle, pops the scoreboard on each handshake
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 32'(o_count), 32'(m_cnt));
      chk("pvalid", 32'(o_pvalid), 32'(m_cnt > 0));
      chk("full", 32'(o_full), 32'(m_cnt == DEPTH));
      chk("empty", 32'(o_empty), 32'(m_cnt == 0));
      chk("overflow", 32'(o_overflow), 32'(m_ovf));
      chk("bad_dest", 32'(o_bad_dest), 32'(m_bad));
      chk("drop_cnt", 32'(o_drop_cnt), 32'(m_drop));
      if (!o_pvalid) chk("pdata_idle", 32'(o_pdata), 32'd0);
      else if (exp_q.size() == 0) chk("pdata_unexpected", 32'(o_pdata), 32'hDEAD_BEEF);
      else chk("pdata_head", 32'(o_pdata), 32'(exp_q[0]));
      if (o_pvalid && i_pready && rst && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  task automatic drive(input bit sv, input logic [15:0] sd, input bit pr, input bit cl);
    i_svalid = sv;
    i_sdata  = sd;
    i_pready = pr;
    i_clear  = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit pr, input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 16'd0, pr, 1'b0);
  endtask

  logic [15:0] pk[8] = '{16'h1005, 16'h2005, 16'h4005, 16'h5005,
                         16'h6005, 16'h8005, 16'h9005, 16'hA005};
  logic [15:0] badp[4] = '{16'h0005, 16'hC005, 16'h1E05, 16'h3005};

  initial begin
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    mon_en = 1;
    rst = 1'b1;
    idle(1'b0, 1);

    // 1: streaming with port ready
    for (int k = 0; k < 8; k++) drive(1'b1, pk[k], 1'b1, 1'b0);
    idle(1'b1, 2);

    // 2: fill stalled, then drain
    for (int k = 0; k < 8; k++) drive(1'b1, pk[k], 1'b0, 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 8);
    idle(1'b0, 1);

    // 3: overflow while full, then clear
    for (int k = 0; k < 8; k++) drive(1'b1, pk[k], 1'b0, 1'b0);
    drive(1'b1, 16'h5123, 1'b0, 1'b0);
    drive(1'b1, 16'h5123, 1'b0, 1'b0);
    idle(1'b0, 1);
    drive(1'b0, 16'd0, 1'b0, 1'b1);
    idle(1'b0, 1);

    // 4: write into full FIFO with simultaneous pop
    drive(1'b1, 16'h9077, 1'b1, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 9);

    // 5: illegal destinations
    for (int k = 0; k < 4; k++) drive(1'b1, badp[k], 1'b0, 1'b0);
    idle(1'b0, 1);
    drive(1'b0, 16'd0, 1'b0, 1'b1);

    // 6: reset with packets buffered
    for (int k = 0; k < 4; k++) drive(1'b1, pk[k], 1'b0, 1'b0);
    drive(1'b1, 16'h0105, 1'b0, 1'b0);
    rst = 1'b0;
    idle(1'b0, 1);
    rst = 1'b1;
    drive(1'b1, 16'h6011, 1'b0, 1'b0);
    drive(1'b1, 16'h2022, 1'b0, 1'b0);
    idle(1'b1, 3);

    // Drop counter saturation
    for (int k = 0; k < 8; k++) drive(1'b1, pk[k], 1'b0, 1'b0);
    for (int k = 0; k < 270; k++) drive(1'b1, 16'h4000 | 16'(k & 9'h1FF), 1'b0, 1'b0);
    drive(1'b1, 16'h5001, 1'b0, 1'b1);
    idle(1'b1, 10);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if ($urandom_range(0, 3) != 0) d[11:9] = 3'd0;
      drive($urandom_range(0, 2) != 0, d, $urandom_range(0, 2) == 0,
            $urandom_range(0, 40) == 0);
      if ($urandom_range(0, 500) == 0) begin
        rst = 1'b0;
        idle(1'b0, 1);
        rst = 1'b1;
      end
    end
    idle(1'b1, 12);

    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
